// File: rtl/conv_operand_feeder.sv
// -----------------------------------------------------------------------------
// conv_operand_feeder
//   Operand supply for the transposed-conv engine. Holds one IFM tensor and one
//   weight set in on-chip RAM (filled through a single load port while idle) and
//   answers the CONV engine's read strobes with one word each, one cycle later.
//   Two independent read pointers walk the memories linearly and wrap, so the
//   engine can re-read the IFM once per filter without a bubble.
//
// Ports
//   clk1        single clock, posedge
//   rst         synchronous reset, active-high (control state and outputs only)
//   load_valid  write strobe for load_addr / load_data
//   load_sel    0 = IFM memory, 1 = weight memory
//   load_addr   word address
//   load_data   write data, LSBs used
//   load_err    one-cycle pulse: the previous write was rejected
//   start_conv  rewind both pointers and enter SERVE
//   conv_done   end of convolution, return to IDLE
//   ifm_read    request next IFM word
//   wgt_read    request next weight word
//   ifm/wgt     requested word, forced to 0 when the matching valid is low
//   ifm_valid   ifm holds a requested word
//   wgt_valid   wgt holds a requested word
//   busy        high while serving reads
// -----------------------------------------------------------------------------
module conv_operand_feeder #(
  parameter int IFM_WIDTH    = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IFM_SIZE     = 14,
  parameter int KERNEL_SIZE  = 3,
  parameter int CI           = 3,
  parameter int CO           = 2,
  localparam int IFM_DEPTH   = CI * IFM_SIZE * IFM_SIZE,
  localparam int WGT_DEPTH   = CO * CI * KERNEL_SIZE * KERNEL_SIZE,
  localparam int AW          = $clog2((IFM_DEPTH > WGT_DEPTH) ? IFM_DEPTH : WGT_DEPTH),
  localparam int DW          = (IFM_WIDTH > WEIGHT_WIDTH) ? IFM_WIDTH : WEIGHT_WIDTH
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic                    load_sel,
  input  logic [AW-1:0]           load_addr,
  input  logic [DW-1:0]           load_data,
  output logic                    load_err,
  input  logic                    start_conv,
  input  logic                    conv_done,
  input  logic                    ifm_read,
  input  logic                    wgt_read,
  output logic [IFM_WIDTH-1:0]    ifm,
  output logic [WEIGHT_WIDTH-1:0] wgt,
  output logic                    ifm_valid,
  output logic                    wgt_valid,
  output logic                    busy
);

  localparam int IPW = $clog2(IFM_DEPTH);
  localparam int WPW = $clog2(WGT_DEPTH);
  localparam logic [AW:0]    IFM_LIM  = (AW+1)'(IFM_DEPTH);
  localparam logic [AW:0]    WGT_LIM  = (AW+1)'(WGT_DEPTH);
  localparam logic [IPW-1:0] IFM_LAST = IPW'(IFM_DEPTH - 1);
  localparam logic [WPW-1:0] WGT_LAST = WPW'(WGT_DEPTH - 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t r_state, w_state_nxt;

  logic [IFM_WIDTH-1:0]    r_mem_ifm [IFM_DEPTH];
  logic [WEIGHT_WIDTH-1:0] r_mem_wgt [WGT_DEPTH];

  logic [IPW-1:0] r_ifm_ptr, w_ifm_raddr;
  logic [WPW-1:0] r_wgt_ptr, w_wgt_raddr;
  logic           w_ifm_rd, w_wgt_rd;
  logic           w_ifm_we, w_wgt_we, w_ld_ok;
  logic           w_idle;

  logic [IFM_WIDTH-1:0]    r_ifm_p1;
  logic [WEIGHT_WIDTH-1:0] r_wgt_p1;
  logic                    r_ifm_vld_p1, r_wgt_vld_p1;
  logic                    r_load_err;

  function automatic logic [IPW-1:0] ifm_next(input logic [IPW-1:0] p);
    return (p == IFM_LAST) ? '0 : p + IPW'(1);
  endfunction

  function automatic logic [WPW-1:0] wgt_next(input logic [WPW-1:0] p);
    return (p == WGT_LAST) ? '0 : p + WPW'(1);
  endfunction

  // FSM
  always_ff @(posedge clk1) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_conv) w_state_nxt = SERVE;
      SERVE:   if (!start_conv && conv_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_idle = (r_state == IDLE);
  assign busy   = (r_state == SERVE);

  // Load port: writes allowed only while idle and only inside the target memory
  assign w_ld_ok  = w_idle && (load_sel ? ({1'b0, load_addr} < WGT_LIM)
                                        : ({1'b0, load_addr} < IFM_LIM));
  assign w_ifm_we = load_valid && !rst && w_ld_ok && !load_sel;
  assign w_wgt_we = load_valid && !rst && w_ld_ok &&  load_sel;

  always_ff @(posedge clk1) begin
    if (w_ifm_we) r_mem_ifm[load_addr[IPW-1:0]] <= load_data[IFM_WIDTH-1:0];
    if (w_wgt_we) r_mem_wgt[load_addr[WPW-1:0]] <= load_data[WEIGHT_WIDTH-1:0];
  end

  always_ff @(posedge clk1) begin
    if (rst) r_load_err <= 1'b0;
    else     r_load_err <= load_valid && !w_ld_ok;
  end

  assign load_err = r_load_err;

  // Read request stage p0: start_conv forces address 0 so a read issued with
  // it returns word 0 and leaves the pointer at 1.
  assign w_ifm_rd    = ifm_read && (busy || start_conv);
  assign w_wgt_rd    = wgt_read && (busy || start_conv);
  assign w_ifm_raddr = start_conv ? '0 : r_ifm_ptr;
  assign w_wgt_raddr = start_conv ? '0 : r_wgt_ptr;

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_ifm_ptr <= '0;
      r_wgt_ptr <= '0;
    end else begin
      if (start_conv || w_ifm_rd) r_ifm_ptr <= w_ifm_rd ? ifm_next(w_ifm_raddr) : '0;
      if (start_conv || w_wgt_rd) r_wgt_ptr <= w_wgt_rd ? wgt_next(w_wgt_raddr) : '0;
    end
  end

  // Registered RAM read, stage p1
  always_ff @(posedge clk1) begin
    if (w_ifm_rd) r_ifm_p1 <= r_mem_ifm[w_ifm_raddr];
    if (w_wgt_rd) r_wgt_p1 <= r_mem_wgt[w_wgt_raddr];
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_ifm_vld_p1 <= 1'b0;
      r_wgt_vld_p1 <= 1'b0;
    end else begin
      r_ifm_vld_p1 <= w_ifm_rd;
      r_wgt_vld_p1 <= w_wgt_rd;
    end
  end

  assign ifm_valid = r_ifm_vld_p1;
  assign wgt_valid = r_wgt_vld_p1;
  assign ifm       = r_ifm_vld_p1 ? r_ifm_p1 : '0;
  assign wgt       = r_wgt_vld_p1 ? r_wgt_p1 : '0;

endmodule

// File: tb/tb_conv_operand_feeder.sv
module tb_conv_operand_feeder;
  localparam int ID = 588;
  localparam int WD = 54;
  localparam int AW = 10;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic          rst, load_valid, load_sel, load_err;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          start_conv, conv_done, ifm_read, wgt_read;
  logic [7:0]    ifm, wgt;
  logic          ifm_valid, wgt_valid, busy;

  conv_operand_feeder dut (
    .clk1(clk1), .rst(rst), .load_valid(load_valid), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .load_err(load_err),
    .start_conv(start_conv), .conv_done(conv_done), .ifm_read(ifm_read),
    .wgt_read(wgt_read), .ifm(ifm), .wgt(wgt), .ifm_valid(ifm_valid),
    .wgt_valid(wgt_valid), .busy(busy)
  );

  typedef struct {int cyc; logic [7:0] d;} exp_t;
  exp_t q_ifm[$];
  exp_t q_wgt[$];
  int   q_err[$];

  logic [7:0] m_ifm [ID];
  logic [7:0] m_wgt [WD];
  int m_iptr = 0, m_wptr = 0;
  bit m_serve = 0, exp_busy = 0;
  int cyc = 0;
  int checks = 0, errors = 0;
  bit mon_en = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  // Reference: memories as arrays, pointers as modular counters, one call per
  // clock with the inputs that will be sampled at the coming edge.
  task automatic model_step();
    int a;
    if (rst) begin
      m_serve = 0; m_iptr = 0; m_wptr = 0;
    end else begin
      if (load_valid) begin
        if (!m_serve && !load_sel && int'(load_addr) < ID) m_ifm[load_addr] = load_data;
        else if (!m_serve && load_sel && int'(load_addr) < WD) m_wgt[load_addr] = load_data;
        else q_err.push_back(cyc + 1);
      end
      if (ifm_read && (m_serve || start_conv)) begin
        a = start_conv ? 0 : m_iptr;
        q_ifm.push_back('{cyc + 1, m_ifm[a]});
        m_iptr = (a + 1) % ID;
      end else if (start_conv) m_iptr = 0;
      if (wgt_read && (m_serve || start_conv)) begin
        a = start_conv ? 0 : m_wptr;
        q_wgt.push_back('{cyc + 1, m_wgt[a]});
        m_wptr = (a + 1) % WD;
      end else if (start_conv) m_wptr = 0;
      if (start_conv) m_serve = 1;
      else if (conv_done) m_serve = 0;
    end
    exp_busy = m_serve;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk1);
  endtask

  task automatic clr();
    rst = 0; load_valid = 0; load_sel = 0; load_addr = '0; load_data = '0;
    start_conv = 0; conv_done = 0; ifm_read = 0; wgt_read = 0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk1);
      #1;
      if (mon_en) begin
        checks++;
        if (busy !== exp_busy) begin
          errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        if (ifm_valid === 1'b1) begin
          checks++;
          if (q_ifm.size() == 0) begin
            errors++; $display("FAIL ifm_unexpected cyc=%0d got=%0d exp=none", cyc, ifm);
          end else begin
            e = q_ifm.pop_front();
            if (e.cyc != cyc || ifm !== e.d) begin
              errors++;
              $display("FAIL ifm_word cyc=%0d got=%0d exp=%0d (due cyc %0d)", cyc, ifm, e.d, e.cyc);
            end
          end
        end else begin
          checks++;
          if (ifm !== 8'd0 || ifm_valid !== 1'b0) begin
            errors++; $display("FAIL ifm_idle cyc=%0d got=%0d/%b exp=0/0", cyc, ifm, ifm_valid);
          end
          if (q_ifm.size() != 0 && q_ifm[0].cyc <= cyc) begin
            errors++; e = q_ifm.pop_front();
            $display("FAIL ifm_missing cyc=%0d got=novalid exp=%0d", cyc, e.d);
          end
        end
        if (wgt_valid === 1'b1) begin
          checks++;
          if (q_wgt.size() == 0) begin
            errors++; $display("FAIL wgt_unexpected cyc=%0d got=%0d exp=none", cyc, wgt);
          end else begin
            e = q_wgt.pop_front();
            if (e.cyc != cyc || wgt !== e.d) begin
              errors++;
              $display("FAIL wgt_word cyc=%0d got=%0d exp=%0d (due cyc %0d)", cyc, wgt, e.d, e.cyc);
            end
          end
        end else begin
          checks++;
          if (wgt !== 8'd0 || wgt_valid !== 1'b0) begin
            errors++; $display("FAIL wgt_idle cyc=%0d got=%0d/%b exp=0/0", cyc, wgt, wgt_valid);
          end
          if (q_wgt.size() != 0 && q_wgt[0].cyc <= cyc) begin
            errors++; e = q_wgt.pop_front();
            $display("FAIL wgt_missing cyc=%0d got=novalid exp=%0d", cyc, e.d);
          end
        end
        if (load_err === 1'b1) begin
          checks++;
          if (q_err.size() == 0 || q_err[0] != cyc) begin
            errors++; $display("FAIL load_err_unexpected cyc=%0d got=1 exp=0", cyc);
          end
          if (q_err.size() != 0) void'(q_err.pop_front());
        end else begin
          checks++;
          if (q_err.size() != 0 && q_err[0] <= cyc) begin
            errors++; void'(q_err.pop_front());
            $display("FAIL load_err_missing cyc=%0d got=%b exp=1", cyc, load_err);
          end
        end
      end
    end
  end

  initial begin
    clr();
    rst = 1;
    tick();
    tick();
    checks++;
    if ({busy, ifm_valid, wgt_valid, load_err, ifm, wgt} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b%b/%0d/%0d exp=all0",
               busy, ifm_valid, wgt_valid, load_err, ifm, wgt);
    end
    clr();
    mon_en = 1;

    // Fill both memories
    for (int k = 0; k < ID; k++) begin
      load_valid = 1; load_sel = 0; load_addr = AW'(k); load_data = 8'(k); tick();
    end
    for (int j = 0; j < WD; j++) begin
      load_valid = 1; load_sel = 1; load_addr = AW'(j); load_data = 8'(j); tick();
    end
    clr(); start_conv = 1; tick(); clr();

    // Full IFM stream, then weight stream across a wrap
    ifm_read = 1; repeat (ID) tick(); clr();
    wgt_read = 1; repeat (60) tick(); clr();

    // Rejected loads: in SERVE, then out of range in IDLE
    load_valid = 1; load_sel = 0; load_addr = 10'd0; load_data = 8'hAA; tick(); clr();
    conv_done = 1; tick(); clr();
    load_valid = 1; load_sel = 0; load_addr = 10'd588; load_data = 8'h55; tick(); clr();
    start_conv = 1; ifm_read = 1; tick(); clr(); tick();

    // Rewind in the middle of a stream
    ifm_read = 1; repeat (10) tick();
    start_conv = 1; tick(); start_conv = 0; tick(); clr(); tick();

    // Reads while idle are ignored
    conv_done = 1; tick(); clr();
    ifm_read = 1; wgt_read = 1; repeat (3) tick();
    start_conv = 1; tick(); clr(); tick();

    // Reset in the middle of a stream
    ifm_read = 1; wgt_read = 1; repeat (20) tick();
    rst = 1; tick(); clr(); tick();
    start_conv = 1; ifm_read = 1; wgt_read = 1; tick();
    start_conv = 0; repeat (10) tick(); clr(); tick();

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      clr();
      rst        = ($urandom_range(0, 199) == 0);
      start_conv = ($urandom_range(0, 49) == 0);
      conv_done  = ($urandom_range(0, 59) == 0);
      ifm_read   = ($urandom_range(0, 9) < 7);
      wgt_read   = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) == 0) begin
        load_valid = 1;
        load_sel   = 1'($urandom_range(0, 1));
        load_addr  = AW'(load_sel ? $urandom_range(0, 63) : $urandom_range(0, 620));
        load_data  = 8'($urandom);
      end
      tick();
    end
    clr();
    repeat (3) tick();

    checks++;
    if (q_ifm.size() != 0) begin
      errors++; $display("FAIL ifm_leftover got=%0d exp=0", q_ifm.size());
    end
    checks++;
    if (q_wgt.size() != 0) begin
      errors++; $display("FAIL wgt_leftover got=%0d exp=0", q_wgt.size());
    end
    checks++;
    if (q_err.size() != 0) begin
      errors++; $display("FAIL err_leftover got=%0d exp=0", q_err.size());
    end
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
